// File: rtl/sigmoid_pipe_if.sv
// sigmoid_pipe_if: valid/ready stream bundle between a sample producer, the sigmoid pipe and its consumer
// Signals: in_valid/in_ready/x (input side), out_valid/out_ready/out (output side), mode (tanh select, only with SIGMOID_TANH_MODE_EN)
// Modports: master = producer/consumer side, slave = sigmoid_pipe side
interface sigmoid_pipe_if #(
  parameter int IN_W = 32,
  parameter int OUT_W = 16
);
  logic in_valid;
  logic in_ready;
  logic signed [IN_W-1:0] x;
  logic out_valid;
  logic out_ready;
  logic signed [OUT_W-1:0] out;
`ifdef SIGMOID_TANH_MODE_EN
  logic mode;
  modport master(output in_valid, x, mode, out_ready, input in_ready, out_valid, out);
  modport slave(input in_valid, x, mode, out_ready, output in_ready, out_valid, out);
`else
  modport master(output in_valid, x, out_ready, input in_ready, out_valid, out);
  modport slave(input in_valid, x, out_ready, output in_ready, out_valid, out);
`endif
endinterface

// File: rtl/sigmoid_pipe.sv
// sigmoid_pipe: 3-stage shift-add piecewise-linear sigmoid with valid/ready backpressure
// Ports: clk, rst (sync, active-high), s (sigmoid_pipe_if.slave: in_valid/in_ready/x in, out_valid/out_ready/out out)
// Option: define SIGMOID_TANH_MODE_EN to add s.mode (1 = tanh via 2*sigmoid(2x)-1)
module sigmoid_pipe #(
  parameter int IN_W = 32,
  parameter int IN_FRAC = 16,
  parameter int OUT_W = 16,
  parameter int OUT_FRAC = 14
) (
  input logic clk,
  input logic rst,
  sigmoid_pipe_if.slave s
);
  localparam int W = IN_W + OUT_W + 2;
  localparam int RS = OUT_FRAC < IN_FRAC ? IN_FRAC - OUT_FRAC : 0;
  localparam int LS = OUT_FRAC < IN_FRAC ? 0 : OUT_FRAC - IN_FRAC;
  localparam logic [IN_W-1:0] ONE = IN_W'(1) << IN_FRAC;
  localparam logic [IN_W-1:0] MAXP = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0] MINN = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0] T_SAT = IN_W'(5) << IN_FRAC;
  localparam logic [IN_W-1:0] T_SEG2 = IN_W'(19) << (IN_FRAC - 3);
  localparam logic [IN_W-1:0] C0 = ONE >> 1;
  localparam logic [IN_W-1:0] C1 = IN_W'(5) << (IN_FRAC - 3);
  localparam logic [IN_W-1:0] C2 = IN_W'((64'd27 << IN_FRAC) >> 5);
  localparam logic signed [W-1:0] ONE_W = W'(1) << IN_FRAC;
  localparam logic signed [W-1:0] HALF = (W'(1) << RS) >> 1;
  localparam logic signed [W-1:0] OUT_MAX = W'(1) << OUT_FRAC;
  localparam logic signed [W-1:0] ZERO = '0;
  logic m_in;
`ifdef SIGMOID_TANH_MODE_EN
  assign m_in = s.mode;
`else
  assign m_in = 1'b0;
`endif
  logic adv;
  logic [IN_W-1:0] xe, a_d, p_d, q;
  logic [1:0] seg_d;
  logic signed [W-1:0] qw, t, r, lo;
  logic [OUT_W-1:0] out_d;
  logic v1_q, neg1_q, m1_q, v2_q, neg2_q, m2_q, v3_q;
  logic [1:0] seg1_q;
  logic [IN_W-1:0] a1_q, p2_q;
  logic [OUT_W-1:0] out_q;
  assign adv = !v3_q || s.out_ready;
  assign s.in_ready = adv;
  assign s.out_valid = v3_q;
  assign s.out = out_q;
  // tanh doubles x with saturation so that sigmoid(2x) can be reused
  assign xe = !m_in ? s.x
            : (s.x[IN_W-1] ^ s.x[IN_W-2]) ? (s.x[IN_W-1] ? MINN : MAXP)
            : {s.x[IN_W-2:0], 1'b0};
  assign a_d = xe == MINN ? MAXP : xe[IN_W-1] ? -xe : xe;
  assign seg_d = a_d >= T_SAT ? 2'd3 : a_d >= T_SEG2 ? 2'd2 : a_d >= ONE ? 2'd1 : 2'd0;
  assign p_d = seg1_q == 2'd0 ? (a1_q >> 2) + C0
             : seg1_q == 2'd1 ? (a1_q >> 3) + C1
             : seg1_q == 2'd2 ? (a1_q >> 5) + C2
             : ONE;
  assign q = neg2_q ? ONE - p2_q : p2_q;
  assign qw = $signed({{(W-IN_W){1'b0}}, q});
  assign t = m2_q ? (qw <<< 1) - ONE_W : qw;
  // round half up (floor after adding half an output LSB) or widen by left shift
  assign r = ((t + HALF) >>> RS) <<< LS;
  assign lo = m2_q ? -OUT_MAX : ZERO;
  assign out_d = OUT_W'(r > OUT_MAX ? OUT_MAX : r < lo ? lo : r);
  always_ff @(posedge clk)
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      out_q <= '0;
    end else if (adv) begin
      v1_q <= s.in_valid;
      neg1_q <= xe[IN_W-1];
      m1_q <= m_in;
      a1_q <= a_d;
      seg1_q <= seg_d;
      v2_q <= v1_q;
      neg2_q <= neg1_q;
      m2_q <= m1_q;
      p2_q <= p_d;
      v3_q <= v2_q;
      if (v2_q) out_q <= out_d;
    end
endmodule
